// File: rtl/sd_dat_bus_receiver.sv
// SD 4-bit DAT bus read-block receiver: start-bit hunt, nibble-to-byte
// assembly, per-line CRC16 check and end-bit check.

module sd_dat_crc_lane #(
  parameter int CRCWidth = 15,
  parameter int BCW      = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           shift,
  input  logic           din,
  input  logic [BCW-1:0] sel,
  output logic           crc_bit
);
  localparam logic [CRCWidth:0] POLY = (CRCWidth+1)'(16'h1021);

  logic [CRCWidth:0] crc;
  logic              fb;

  assign fb      = crc[CRCWidth] ^ din;
  assign crc_bit = crc[sel];

  always_ff @(posedge clk) begin
    if (rst || clr)
      crc <= '0;
    else if (shift)
      crc <= {crc[CRCWidth-1:0], 1'b0} ^ ({(CRCWidth+1){fb}} & POLY);
  end
endmodule

module sd_dat_bus_receiver #(
  parameter int BLOCKBYTES    = 512,
  parameter int CRCWidth      = 15,
  parameter int TIMEOUTCYCLES = 65535,
  parameter int TOWidth       = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENA,
  input  logic [3:0] INPUTBUS,
  output logic [7:0] DATAOUT,
  output logic       DATAVALID,
  output logic       COMPLT,
  output logic       CRCERR,
  output logic       ENDERR,
  output logic       TIMEOUT
);
  localparam int                BCW      = $clog2(CRCWidth + 1);
  localparam logic [11:0]       NIB_LAST = 12'(2*BLOCKBYTES - 1);
  localparam logic [TOWidth:0]  TO_MAX   = (TOWidth+1)'(TIMEOUTCYCLES);
  localparam logic [TOWidth:0]  TO_ONE   = (TOWidth+1)'(1);
  localparam logic [BCW-1:0]    BIT_TOP  = BCW'(CRCWidth);

  typedef enum logic [2:0] {IDLE, WAIT_START, DATA, CRC, ENDBIT, DONE} state_t;

  state_t           state, state_nxt;
  logic [11:0]      nib_cnt;
  logic [BCW-1:0]   bit_cnt;
  logic [TOWidth:0] to_cnt;
  logic [3:0]       hi_nib;
  logic             mismatch;
  logic [3:0]       crc_bits;
  logic             abort;
  logic             crc_clr;
  logic             crc_shift;

  assign abort     = (state != IDLE) && !ENA;
  assign crc_clr   = (state == IDLE) && ENA;
  assign crc_shift = (state == DATA) && ENA;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    sd_dat_crc_lane #(.CRCWidth(CRCWidth), .BCW(BCW)) u_lane (
      .clk    (CLK),
      .rst    (RST),
      .clr    (crc_clr),
      .shift  (crc_shift),
      .din    (INPUTBUS[i]),
      .sel    (bit_cnt),
      .crc_bit(crc_bits[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:       if (ENA) state_nxt = WAIT_START;
        WAIT_START: if (INPUTBUS == 4'b0000) state_nxt = DATA;
                    else if (to_cnt >= TO_MAX) state_nxt = DONE;
        DATA:       if (nib_cnt == NIB_LAST) state_nxt = CRC;
        CRC:        if (bit_cnt == '0) state_nxt = ENDBIT;
        ENDBIT:     state_nxt = DONE;
        DONE:       state_nxt = DONE;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      DATAOUT   <= 8'h00;
      DATAVALID <= 1'b0;
      COMPLT    <= 1'b0;
      CRCERR    <= 1'b0;
      ENDERR    <= 1'b0;
      TIMEOUT   <= 1'b0;
      nib_cnt   <= '0;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      hi_nib    <= '0;
      mismatch  <= 1'b0;
    end else begin
      DATAVALID <= 1'b0;
      if (abort) begin
        // Leaving via ENA low: aborted blocks never report, finished ones clear.
        COMPLT  <= 1'b0;
        CRCERR  <= 1'b0;
        ENDERR  <= 1'b0;
        TIMEOUT <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            COMPLT  <= 1'b0;
            CRCERR  <= 1'b0;
            ENDERR  <= 1'b0;
            TIMEOUT <= 1'b0;
            if (ENA) begin
              to_cnt   <= '0;
              mismatch <= 1'b0;
            end
          end
          WAIT_START: begin
            if (INPUTBUS == 4'b0000) nib_cnt <= '0;
            else if (to_cnt >= TO_MAX) begin
              TIMEOUT <= 1'b1;
              COMPLT  <= 1'b1;
            end else to_cnt <= to_cnt + TO_ONE;
          end
          DATA: begin
            if (!nib_cnt[0]) hi_nib <= INPUTBUS;
            else begin
              DATAOUT   <= {hi_nib, INPUTBUS};
              DATAVALID <= 1'b1;
            end
            nib_cnt <= nib_cnt + 12'd1;
            if (nib_cnt == NIB_LAST) bit_cnt <= BIT_TOP;
          end
          CRC: begin
            if (INPUTBUS != crc_bits) mismatch <= 1'b1;
            bit_cnt <= bit_cnt - BCW'(1);
          end
          ENDBIT: begin
            ENDERR <= (INPUTBUS != 4'b1111);
            CRCERR <= mismatch;
            COMPLT <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/sd_dat_bus_receiver.md
Name: sd_dat_bus_receiver

Overview:
Host-side receiver for the SD 4-bit DAT bus on read transfers. It waits for the card's start bit and captures one data block (BLOCKBYTES bytes, 2 nibbles per byte). It checks the per-line CRC16 and the end bit, and streams the assembled bytes to the host buffer with a one-cycle valid strobe. It is the counterpart of the host-side DAT write-block transmitter in the SD card path.

Parameters:
BLOCKBYTES, 512, bytes per data block (1024 nibble cycles at 4 lines)
CRCWidth, 15, CRC register MSB index (CRC16 is [15:0])
TIMEOUTCYCLES, 65535, maximum cycles in WAIT_START before timeout
TOWidth, 15, MSB index of the timeout counter; TIMEOUTCYCLES must fit in it

Ports:
CLK  input  1  system clock, also the SD clock; DAT is sampled on posedge
RST  input  1  synchronous reset, active-high
ENA  input  1  arm receiver; held high for the whole transfer; low aborts and idles the block
INPUTBUS  input  4  SD DAT[3:0] lines; DAT3 is the MSB of each nibble
DATAOUT  output  8  assembled byte
DATAVALID  output  1  one-cycle strobe; DATAOUT is valid in that cycle
COMPLT  output  1  block finished (good or bad); held until ENA falls
CRCERR  output  1  at least one line's CRC mismatched; valid when COMPLT=1
ENDERR  output  1  end bit was not 4'b1111; valid when COMPLT=1
TIMEOUT  output  1  no start bit within TIMEOUTCYCLES; valid when COMPLT=1

Behaviour:
- Clock and reset: single clock domain. All state changes on posedge CLK. RST is synchronous and active-high and has priority over ENA.
- Reset values: state=IDLE; DATAOUT=8'h00; DATAVALID, COMPLT, CRCERR, ENDERR, TIMEOUT all 0; counters 0; CRC registers 0.
- States: IDLE, WAIT_START, DATA, CRC, ENDBIT, DONE.
- IDLE:
  - All flags are held at 0.
  - ENA=1 moves to WAIT_START and clears the timeout counter and all four CRC registers.
- WAIT_START:
  - Start bit is INPUTBUS==4'b0000. On detection, go to DATA with the nibble counter at 0.
  - Any other value, including a partial-low pattern, is ignored and increments the timeout counter.
  - When the counter reaches TIMEOUTCYCLES, set TIMEOUT=1 and COMPLT=1 and go to DONE.
- DATA:
  - Each cycle samples one nibble. Each line i feeds bit INPUTBUS[i] into its own CRC16: polynomial x^16+x^12+x^5+1, init 0, MSB-first shift.
  - Even nibble index: latch as the high nibble. Odd index: DATAOUT <= {high, INPUTBUS}.
  - DATAVALID=1 in the cycle after the odd nibble's capture edge, for exactly one cycle.
  - After nibble 2*BLOCKBYTES-1, go to CRC with the bit counter at CRCWidth.
- CRC:
  - 16 cycles. Line i's received bit is compared against its computed CRC bit [counter], MSB first. Any mismatch sets a sticky mismatch bit.
  - CRC registers do not update in this state.
- ENDBIT:
  - One cycle. ENDERR <= (INPUTBUS != 4'b1111); CRCERR <= sticky mismatch; COMPLT <= 1.
  - Go to DONE.
  - The last DATAVALID of the block occurs in the first CRC cycle.
- DONE:
  - COMPLT and the error flags are held.
  - ENA=0 returns to IDLE, clearing COMPLT and all flags the next cycle.
- ENA falling in any state other than IDLE: return to IDLE next cycle.
  - No COMPLT is raised, and no further DATAVALID is produced.
  - A partially assembled byte is discarded.
- RST mid-transfer: immediate return to IDLE with reset values. No DATAVALID is issued on the reset cycle.
- Simultaneous RST and ENA: reset wins.
- Counter widths:
  - Nibble counter is 12 bits, sized for at least 2*BLOCKBYTES.
  - Timeout counter saturates and does not wrap.
- ENA held high after DONE: no re-arm. A new block requires ENA low for at least one cycle.

Test Plan:
- All-zero block (start 0000, 1024×0000, CRC 16×0000, end 1111):
  - 512 DATAVALID pulses, each with DATAOUT=8'h00.
  - COMPLT=1, CRCERR=0, ENDERR=0, TIMEOUT=0.
- Block with bytes 8'h00..8'hFF repeated twice, correct CRCs from the bench reference model:
  - Bytes appear in order, with the first DATAVALID 2 cycles after the start-bit edge + 1.
  - COMPLT=1 with no errors.
- Same block with bit 7 of line 2's CRC inverted:
  - Data is still delivered as 512 bytes.
  - CRCERR=1, ENDERR=0.
- Correct block with end nibble 4'b1110: ENDERR=1, CRCERR=0.
- ENA high with INPUTBUS held at 4'b1111 and TIMEOUTCYCLES=100:
  - TIMEOUT=1 and COMPLT=1 at cycle 101.
  - No DATAVALID pulses.
- ENA dropped after 300 bytes, then a fresh full block sent:
  - Aborted block yields exactly 300 DATAVALID pulses and no COMPLT.
  - Second block completes cleanly.
  - Repeat the same sequence with RST pulsed at byte 300: same outcome.
